// File: rtl/multi_sram_bank_pkg.sv
// Shared constants for the multi-bank SRAM and the controller that sits above it.
// Optional build macro: SRAM_OUT_CLEAR_EN (see single_sram_bank).
package multi_sram_bank_pkg;

    // Default geometry; modules expose these as overridable parameters.
    localparam int unsigned NUM_SRAMS_DEF      = 8;
    localparam int unsigned MAX_ADDR_WIDTH_DEF = 12;
    localparam int unsigned SRAM_DEPTH_DEF     = 4096;
    localparam int unsigned INT8_SIZE_DEF      = 8;
    localparam int unsigned SRAM_WIDTH_O_DEF   = 32;

    // Number of index bits needed to address a memory of the given depth.
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/multi_sram_bank_if.sv
// Flat per-bank request/response bundle between the SRAM controller and the bank array.
// Bank i occupies bit i of en/we and slice i of addr, data_in and data_out.
interface multi_sram_bank_if
    import multi_sram_bank_pkg::*;
#(
    parameter int unsigned NUM_SRAMS      = NUM_SRAMS_DEF,
    parameter int unsigned MAX_ADDR_WIDTH = MAX_ADDR_WIDTH_DEF,
    parameter int unsigned INT8_SIZE      = INT8_SIZE_DEF,
    parameter int unsigned SRAM_WIDTH_O   = SRAM_WIDTH_O_DEF
);

    logic [NUM_SRAMS-1:0]                en;
    logic [NUM_SRAMS-1:0]                we;
    logic [NUM_SRAMS*MAX_ADDR_WIDTH-1:0] addr;
    logic [NUM_SRAMS*INT8_SIZE-1:0]      data_in;
    logic [NUM_SRAMS*SRAM_WIDTH_O-1:0]   data_out;

    // Controller side drives requests and consumes read data.
    modport master (
        output en,
        output we,
        output addr,
        output data_in,
        input  data_out
    );

    // Bank array side consumes requests and returns registered read data.
    modport slave (
        input  en,
        input  we,
        input  addr,
        input  data_in,
        output data_out
    );

endinterface

// File: rtl/single_sram_bank.sv
// One single-port synchronous SRAM bank with write-first, sign-extending registered output.
// Out-of-range addresses drop writes and return zero. Memory is never reset; only the
// output register clears asynchronously. With SRAM_OUT_CLEAR_EN defined the output
// register loads zero on every edge where the bank is not enabled, otherwise it holds.
module single_sram_bank
    import multi_sram_bank_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = MAX_ADDR_WIDTH_DEF,
    parameter int unsigned DEPTH      = SRAM_DEPTH_DEF,
    parameter int unsigned WORD_WIDTH = INT8_SIZE_DEF,
    parameter int unsigned OUT_WIDTH  = SRAM_WIDTH_O_DEF
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic [OUT_WIDTH-1:0]  data_out
);

    localparam int unsigned IDX_W = idx_width(DEPTH);

    logic [WORD_WIDTH-1:0] mem [DEPTH];

    logic                  in_range_c;
    logic                  wr_c;
    logic [IDX_W-1:0]      idx_c;
    logic [WORD_WIDTH-1:0] word_c;
    logic [OUT_WIDTH-1:0]  out_nxt_c;

    // Decode the access: range check, write qualification and the word to present.
    always_comb begin
        in_range_c = 1'b0;
        wr_c       = 1'b0;
        idx_c      = '0;
        word_c     = '0;

        in_range_c = (32'(addr) < DEPTH);
        idx_c      = IDX_W'(addr);
        // Accesses seen while reset is held must not disturb the array.
        wr_c       = rst && en && we && in_range_c;

        if (in_range_c) begin
            word_c = we ? data_in : mem[idx_c];
        end
    end

    // Next output value: sign-extended word when enabled, otherwise hold or clear.
    always_comb begin
        out_nxt_c = data_out;
        if (en) begin
            out_nxt_c = OUT_WIDTH'($signed(word_c));
        end else begin
`ifdef SRAM_OUT_CLEAR_EN
            out_nxt_c = '0;
`else
            out_nxt_c = data_out;
`endif
        end
    end

    // Storage array; writes only, contents undefined until written.
    always_ff @(posedge clk) begin
        if (wr_c) begin
            mem[idx_c] <= data_in;
        end
    end

    // Registered read data with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out <= '0;
        end else begin
            data_out <= out_nxt_c;
        end
    end

endmodule

// File: rtl/multi_sram_bank.sv
// Array of NUM_SRAMS fully independent SRAM banks behind one flat interface.
// The top only slices the flat vectors; all behaviour lives in single_sram_bank.
// Optional build macro: SRAM_OUT_CLEAR_EN (clear idle bank outputs each edge).
module multi_sram_bank
    import multi_sram_bank_pkg::*;
#(
    parameter int unsigned NUM_SRAMS      = NUM_SRAMS_DEF,
    parameter int unsigned MAX_ADDR_WIDTH = MAX_ADDR_WIDTH_DEF,
    parameter int unsigned SRAM_DEPTH     = SRAM_DEPTH_DEF,
    parameter int unsigned INT8_SIZE      = INT8_SIZE_DEF,
    parameter int unsigned SRAM_WIDTH_O   = SRAM_WIDTH_O_DEF
)(
    input  logic             clk,
    input  logic             rst,
    multi_sram_bank_if.slave bus
);

    // One bank per slice of the flat request/response vectors.
    for (genvar i = 0; i < NUM_SRAMS; i++) begin : g_bank
        single_sram_bank #(
            .ADDR_WIDTH (MAX_ADDR_WIDTH),
            .DEPTH      (SRAM_DEPTH),
            .WORD_WIDTH (INT8_SIZE),
            .OUT_WIDTH  (SRAM_WIDTH_O)
        ) u_bank (
            .clk      (clk),
            .rst      (rst),
            .en       (bus.en[i]),
            .we       (bus.we[i]),
            .addr     (bus.addr[i*MAX_ADDR_WIDTH +: MAX_ADDR_WIDTH]),
            .data_in  (bus.data_in[i*INT8_SIZE +: INT8_SIZE]),
            .data_out (bus.data_out[i*SRAM_WIDTH_O +: SRAM_WIDTH_O])
        );
    end

endmodule

// File: tb/tb_multi_sram_bank.sv
// Testbench for multi_sram_bank: directed scenarios plus randomized traffic
// checked against a per-bank array model of memory and expected output.
`timescale 1ns/1ps
module tb_multi_sram_bank;

    localparam int unsigned NS    = 8;
    localparam int unsigned MAW   = 13;
    localparam int unsigned DEPTH = 4096;
    localparam int unsigned WW    = 8;
    localparam int unsigned OW    = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    multi_sram_bank_if #(
        .NUM_SRAMS(NS), .MAX_ADDR_WIDTH(MAW), .INT8_SIZE(WW), .SRAM_WIDTH_O(OW)
    ) bus ();

    multi_sram_bank #(
        .NUM_SRAMS(NS), .MAX_ADDR_WIDTH(MAW), .SRAM_DEPTH(DEPTH),
        .INT8_SIZE(WW), .SRAM_WIDTH_O(OW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: memory image, written-flags, and expected output per bank.
    logic [7:0]    mem_m   [NS][DEPTH];
    bit            known_m [NS][DEPTH];
    logic [OW-1:0] exp_q   [NS];
    bit            exp_ok  [NS];
    int            a_v     [NS];
    int            d_v     [NS];
    int            tests    = 0;
    int            failures = 0;

    function automatic logic [OW-1:0] sext(input int d);
        int v;
        v = (d >= 128) ? d - 256 : d;
        return OW'(v);
    endfunction

    task automatic idle_inputs();
        bus.en = '0;
        bus.we = '0;
        bus.addr = '0;
        bus.data_in = '0;
        for (int i = 0; i < NS; i++) begin
            a_v[i] = 0;
            d_v[i] = 0;
        end
    endtask

    // Drive one cycle from a_v/d_v with the given enables, then advance the model.
    task automatic apply(input logic [NS-1:0] e, input logic [NS-1:0] w);
        for (int i = 0; i < NS; i++) begin
            bus.addr[i*MAW +: MAW]  = MAW'(a_v[i]);
            bus.data_in[i*WW +: WW] = WW'(d_v[i]);
        end
        bus.en = e;
        bus.we = w;
        @(posedge clk);
        for (int i = 0; i < NS; i++) begin
            if (e[i]) begin
                if (a_v[i] >= int'(DEPTH)) begin
                    exp_q[i]  = '0;
                    exp_ok[i] = 1'b1;
                end else if (w[i]) begin
                    mem_m[i][a_v[i]]   = 8'(d_v[i]);
                    known_m[i][a_v[i]] = 1'b1;
                    exp_q[i]           = sext(d_v[i]);
                    exp_ok[i]          = 1'b1;
                end else begin
                    exp_q[i]  = sext(int'(mem_m[i][a_v[i]]));
                    exp_ok[i] = known_m[i][a_v[i]];
                end
            end else begin
`ifdef SRAM_OUT_CLEAR_EN
                exp_q[i]  = '0;
                exp_ok[i] = 1'b1;
`endif
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        bus.en = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NS; i++) begin
            tests++;
            if (bus.data_out[i*OW +: OW] !== '0) begin
                failures++;
                $display("FAIL reset_clear bank %0d: got %h want 0", i, bus.data_out[i*OW +: OW]);
            end
            exp_q[i]  = '0;
            exp_ok[i] = 1'b1;
        end
        idle_inputs();
        rst = 1'b1;
        d_v[0] = 8'h3A;
        apply(8'h01, 8'h01);
        apply(8'h01, 8'h00);
        tests++;
        if (bus.data_out[0 +: OW] !== 32'h0000003A) begin
            failures++;
            $display("FAIL reset_first_read: got %h want 0000003a", bus.data_out[0 +: OW]);
        end
    endtask

    task automatic test_write_read();
        logic [7:0]    vals [2];
        logic [OW-1:0] want [2];
        vals[0] = 8'h7F; want[0] = 32'h0000007F;
        vals[1] = 8'h80; want[1] = 32'hFFFFFF80;
        for (int k = 0; k < 2; k++) begin
            idle_inputs();
            a_v[2] = 5; d_v[2] = int'(vals[k]);
            apply(8'h04, 8'h04);
            a_v[2] = 6; d_v[2] = 1;
            apply(8'h04, 8'h04);
            a_v[2] = 5;
            apply(8'h04, 8'h00);
            tests++;
            if (bus.data_out[2*OW +: OW] !== want[k]) begin
                failures++;
                $display("FAIL write_read bank 2: got %h want %h", bus.data_out[2*OW +: OW], want[k]);
            end
        end
    endtask

    task automatic test_independence();
        idle_inputs();
        for (int i = 0; i < NS; i++) begin
            a_v[i] = 3;
            d_v[i] = 8'h30 + i;
        end
        apply('1, '1);
        d_v[0] = 8'h11;
        d_v[7] = 8'h22;
        apply(8'h81, 8'h81);
        apply('1, '0);
        tests++;
        if (bus.data_out[0 +: OW] !== 32'h00000011) begin
            failures++;
            $display("FAIL indep bank 0: got %h want 00000011", bus.data_out[0 +: OW]);
        end
        tests++;
        if (bus.data_out[7*OW +: OW] !== 32'h00000022) begin
            failures++;
            $display("FAIL indep bank 7: got %h want 00000022", bus.data_out[7*OW +: OW]);
        end
        for (int i = 1; i < NS - 1; i++) begin
            tests++;
            if (bus.data_out[i*OW +: OW] !== exp_q[i]) begin
                failures++;
                $display("FAIL indep_other bank %0d: got %h want %h", i, bus.data_out[i*OW +: OW], exp_q[i]);
            end
        end
    endtask

    task automatic test_write_first_hold();
        logic [OW-1:0] want_idle;
`ifdef SRAM_OUT_CLEAR_EN
        want_idle = '0;
`else
        want_idle = 32'hFFFFFFF0;
`endif
        idle_inputs();
        a_v[1] = 9; d_v[1] = 8'hF0;
        apply(8'h02, 8'h02);
        tests++;
        if (bus.data_out[1*OW +: OW] !== 32'hFFFFFFF0) begin
            failures++;
            $display("FAIL write_first bank 1: got %h want fffffff0", bus.data_out[1*OW +: OW]);
        end
        apply(8'h00, 8'h00);
        apply(8'h00, 8'h00);
        tests++;
        if (bus.data_out[1*OW +: OW] !== want_idle) begin
            failures++;
            $display("FAIL idle_hold bank 1: got %h want %h", bus.data_out[1*OW +: OW], want_idle);
        end
    endtask

    task automatic test_out_of_range();
        int            addrs [6];
        bit            wrs   [6];
        logic [OW-1:0] want  [6];
        addrs[0] = 0;         wrs[0] = 1; want[0] = 32'h0000005A;
        addrs[1] = DEPTH - 1; wrs[1] = 1; want[1] = 32'h00000066;
        addrs[2] = DEPTH;     wrs[2] = 1; want[2] = 32'h00000000;
        addrs[3] = DEPTH - 1; wrs[3] = 0; want[3] = 32'h00000066;
        addrs[4] = DEPTH;     wrs[4] = 0; want[4] = 32'h00000000;
        addrs[5] = 0;         wrs[5] = 0; want[5] = 32'h0000005A;
        idle_inputs();
        for (int k = 0; k < 6; k++) begin
            a_v[3] = addrs[k];
            d_v[3] = (k == 0) ? 8'h5A : (k == 1) ? 8'h66 : 8'h77;
            apply(8'h08, wrs[k] ? 8'h08 : 8'h00);
            tests++;
            if (bus.data_out[3*OW +: OW] !== want[k]) begin
                failures++;
                $display("FAIL out_of_range step %0d addr %0d: got %h want %h",
                         k, addrs[k], bus.data_out[3*OW +: OW], want[k]);
            end
        end
    endtask

    task automatic test_mid_reset();
        idle_inputs();
        a_v[4] = 0;  d_v[4] = 8'h05;
        a_v[5] = 20; d_v[5] = 8'h12;
        apply(8'h30, 8'h30);
        #1 rst = 1'b0;
        #1;
        for (int i = 0; i < NS; i++) begin
            tests++;
            if (bus.data_out[i*OW +: OW] !== '0) begin
                failures++;
                $display("FAIL async_clear bank %0d: got %h want 0", i, bus.data_out[i*OW +: OW]);
            end
            exp_q[i]  = '0;
            exp_ok[i] = 1'b1;
        end
        // Writes attempted while reset is held must not reach memory.
        bus.en = '1;
        bus.we = '1;
        bus.addr[4*MAW +: MAW] = MAW'(0);
        bus.addr[5*MAW +: MAW] = MAW'(20);
        bus.data_in = {NS{8'h99}};
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (bus.data_out !== '0) begin
            failures++;
            $display("FAIL reset_hold: got %h want 0", bus.data_out);
        end
        idle_inputs();
        rst = 1'b1;
        a_v[4] = 0;
        a_v[5] = 20;
        apply(8'h30, 8'h00);
        tests++;
        if (bus.data_out[4*OW +: OW] !== 32'h00000005) begin
            failures++;
            $display("FAIL mid_reset bank 4: got %h want 00000005", bus.data_out[4*OW +: OW]);
        end
        tests++;
        if (bus.data_out[5*OW +: OW] !== 32'h00000012) begin
            failures++;
            $display("FAIL reset_write_gate bank 5: got %h want 00000012", bus.data_out[5*OW +: OW]);
        end
    endtask

    task automatic test_random();
        logic [NS-1:0] e;
        logic [NS-1:0] w;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NS; i++) begin
                int sel;
                e[i] = 1'($urandom_range(0, 1));
                w[i] = 1'($urandom_range(0, 1));
                sel  = int'($urandom_range(0, 9));
                if (sel < 8)       a_v[i] = int'($urandom_range(0, 15));
                else if (sel == 8) a_v[i] = DEPTH - 1;
                else               a_v[i] = DEPTH + int'($urandom_range(0, DEPTH - 1));
                d_v[i] = int'($urandom_range(0, 255));
            end
            apply(e, w);
            for (int i = 0; i < NS; i++) begin
                if (exp_ok[i]) begin
                    tests++;
                    if (bus.data_out[i*OW +: OW] !== exp_q[i]) begin
                        failures++;
                        $display("FAIL random cycle %0d bank %0d: got %h want %h",
                                 c, i, bus.data_out[i*OW +: OW], exp_q[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NS; i++) begin
            exp_q[i]  = '0;
            exp_ok[i] = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                known_m[i][j] = 1'b0;
                mem_m[i][j]   = '0;
            end
        end
        test_reset();
        test_write_read();
        test_independence();
        test_write_first_hold();
        test_out_of_range();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
